// File: rtl/phy_stim_gen.sv
// phy_stim_gen: start/done driven stimulus source for a PHY under test, plus a
// checker comparing the behavioural and synthesized PHY output streams.
// Optional feature: define PHY_STIM_LFSR_EN to build the LFSR pattern (mode 2).
// Without it mode 2 decrements like mode 0 and no LFSR logic exists.
module phy_stim_gen #(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       NUM_WORDS    = 1600,
  parameter int unsigned       VALID_GAP    = 0,
  parameter int unsigned       DRAIN_CYCLES = 8,
  parameter int unsigned       CNT_W        = 16,
  parameter logic [DATA_W-1:0] LFSR_TAPS    = DATA_W'(32'h80200003)
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [DATA_W-1:0] dataOut,
  input  logic              validOut,
  input  logic [DATA_W-1:0] dataOut_est,
  input  logic              validOut_est,
  output logic [DATA_W-1:0] dataIn,
  output logic              validIn,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  mismatch_cnt
);

  // Counters hold 0..limit-1; a zero limit still gets a 1-bit counter.
  localparam int unsigned BeatW  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned GapW   = (VALID_GAP > 1) ? $clog2(VALID_GAP) : 1;
  localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [BeatW-1:0]  LastBeat  = BeatW'(NUM_WORDS - 1);
  localparam logic [GapW-1:0]   LastGap   = GapW'((VALID_GAP > 0) ? VALID_GAP - 1 : 0);
  // DRAIN_CYCLES = 0 degenerates to a single drain cycle.
  localparam logic [DrainW-1:0] LastDrain = DrainW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic [1:0]         mode_q, mode_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [GapW-1:0]    gap_q, gap_d;
  logic [DrainW-1:0]  drain_q, drain_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [DATA_W-1:0]  next_data;
  logic [DATA_W-1:0]  seed_eff;
  logic               mismatch;
  logic               chk_en;

  // Pattern step applied in the cycle after each non-final beat.
  always_comb begin
    next_data = data_q;
    unique case (mode_q)
      2'd0: next_data = data_q - DATA_W'(1);
      2'd1: next_data = data_q + DATA_W'(1);
`ifdef PHY_STIM_LFSR_EN
      2'd2: next_data = {data_q[DATA_W-2:0], ^(data_q & LFSR_TAPS)};
`else
      2'd2: next_data = data_q - DATA_W'(1);
`endif
      2'd3: next_data = data_q;
      default: next_data = data_q;
    endcase
  end

`ifdef PHY_STIM_LFSR_EN
  // An all-zero LFSR state would lock up, so substitute all ones.
  assign seed_eff = ((mode == 2'd2) && (seed == '0)) ? '1 : seed;
`else
  logic unused_taps;
  assign unused_taps = ^LFSR_TAPS;
  assign seed_eff    = seed;
`endif

  assign mismatch = (validOut != validOut_est) ||
                    (validOut && validOut_est && (dataOut != dataOut_est));
  assign chk_en   = (state_q == StRun) || (state_q == StDrain);

  // Next-state: run sequencing, beat/gap/drain counting and the checker.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    mode_d  = mode_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    drain_d = drain_q;
    done_d  = done_q;
    error_d = error_q;
    cnt_d   = cnt_q;

    if (chk_en && mismatch) begin
      error_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          data_d  = seed_eff;
          mode_d  = mode;
          valid_d = 1'b1;
          beat_d  = '0;
          gap_d   = '0;
          drain_d = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (valid_q) begin
          if (beat_q == LastBeat) begin
            // Final beat: data holds its last value through drain.
            valid_d = 1'b0;
            drain_d = '0;
            state_d = StDrain;
          end else begin
            beat_d  = beat_q + BeatW'(1);
            data_d  = next_data;
            gap_d   = '0;
            valid_d = (VALID_GAP == 0);
          end
        end else if (gap_q == LastGap) begin
          valid_d = 1'b1;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      StDrain: begin
        if (drain_q == LastDrain) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + DrainW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      data_q  <= '1;
      valid_q <= 1'b0;
      mode_q  <= 2'd0;
      beat_q  <= '0;
      gap_q   <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      mode_q  <= mode_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      drain_q <= drain_d;
      done_q  <= done_d;
      error_q <= error_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dataIn       = data_q;
  assign validIn      = valid_q;
  assign busy         = chk_en;
  assign done         = done_q;
  assign error        = error_q;
  assign mismatch_cnt = cnt_q;

endmodule

// File: tb/tb_phy_stim_gen.sv
// Bench for phy_stim_gen: two instances (default build and a short gapped run
// with a 2-bit counter) driven in lockstep and compared to a timing model
// derived from beat period, drain length and precomputed pattern values.
module tb_phy_stim_gen;

  localparam int NA = 1600, GA = 0, DA = 8;
  localparam int NB = 5,    GB = 2, DB = 3;
  localparam int MAXA = 65535, MAXB = 3;

  logic        clk_2f = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] seed = '0;
  logic [31:0] dataOut = '0, dataOut_est = '0;
  logic        validOut = 1'b0, validOut_est = 1'b0;

  logic [31:0] data_a, data_b;
  logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  // Expected outputs; they persist between runs (idle/done hold values).
  logic [31:0] ed_a, ed_b;
  logic        ev_a, ev_b, eb_a, eb_b, edn_a, edn_b, eer_a, eer_b;
  int          ec_a, ec_b;

  always #5 clk_2f = ~clk_2f;

  phy_stim_gen u_dut_a (
    .clk_2f(clk_2f), .reset(reset), .start(start), .mode(mode), .seed(seed),
    .dataOut(dataOut), .validOut(validOut), .dataOut_est(dataOut_est),
    .validOut_est(validOut_est), .dataIn(data_a), .validIn(valid_a), .busy(busy_a),
    .done(done_a), .error(err_a), .mismatch_cnt(cnt_a)
  );

  phy_stim_gen #(
    .NUM_WORDS(NB), .VALID_GAP(GB), .DRAIN_CYCLES(DB), .CNT_W(2)
  ) u_dut_b (
    .clk_2f(clk_2f), .reset(reset), .start(start), .mode(mode), .seed(seed),
    .dataOut(dataOut), .validOut(validOut), .dataOut_est(dataOut_est),
    .validOut_est(validOut_est), .dataIn(data_b), .validIn(valid_b), .busy(busy_b),
    .done(done_b), .error(err_b), .mismatch_cnt(cnt_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    check_eq("a.data",  data_a,        ed_a);
    check_eq("a.valid", {31'd0, valid_a}, {31'd0, ev_a});
    check_eq("a.busy",  {31'd0, busy_a},  {31'd0, eb_a});
    check_eq("a.done",  {31'd0, done_a},  {31'd0, edn_a});
    check_eq("a.error", {31'd0, err_a},   {31'd0, eer_a});
    check_eq("a.cnt",   {16'd0, cnt_a},   ec_a);
    check_eq("b.data",  data_b,        ed_b);
    check_eq("b.valid", {31'd0, valid_b}, {31'd0, ev_b});
    check_eq("b.busy",  {31'd0, busy_b},  {31'd0, eb_b});
    check_eq("b.done",  {31'd0, done_b},  {31'd0, edn_b});
    check_eq("b.error", {31'd0, err_b},   {31'd0, eer_b});
    check_eq("b.cnt",   {30'd0, cnt_b},   ec_b);
  endtask

  task automatic model_reset();
    ed_a = '1; ev_a = 0; eb_a = 0; edn_a = 0; eer_a = 0; ec_a = 0;
    ed_b = '1; ev_b = 0; eb_b = 0; edn_b = 0; eer_b = 0; ec_b = 0;
  endtask

  // Timing at c cycles after the start edge: beats every g+1 cycles, n beats,
  // d drain cycles, done afterwards; nu = pattern steps applied so far.
  task automatic model_at(input int n, input int g, input int d, input int c,
                          output logic ev, output logic eb, output logic edn, output int nu);
    int p, l;
    p   = g + 1;
    l   = 1 + (n - 1) * p;
    ev  = (c <= l) && (((c - 1) % p) == 0);
    eb  = (c <= l + d);
    edn = (c > l + d);
    if (c < 2) nu = 0;
    else begin
      nu = (c - 2) / p + 1;
      if (nu > n - 1) nu = n - 1;
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] v, input logic [1:0] m);
    case (m)
      2'd0: return v - 32'd1;
      2'd1: return v + 32'd1;
`ifdef PHY_STIM_LFSR_EN
      2'd2: return {v[30:0], ^(v & 32'h80200003)};
`else
      2'd2: return v - 32'd1;
`endif
      default: return v;
    endcase
  endfunction

  // Random PHY streams; inj = percent chance of a forced disagreement.
  task automatic drive_phy(input int inj, output logic mm);
    logic vo, voe;
    logic [31:0] d, de;
    vo = 1'($urandom_range(1)); d = $urandom; voe = vo; de = d;
    if (int'($urandom_range(99)) < inj) begin
      if ($urandom_range(1) == 0) voe = ~vo;
      else de = d ^ (32'd1 << $urandom_range(31));
    end
    if (!vo && !voe) de = $urandom;
    validOut = vo; validOut_est = voe; dataOut = d; dataOut_est = de;
    mm = (vo != voe) || (vo && voe && (d != de));
  endtask

  task automatic idle_cycles(input int n);
    logic mm;
    repeat (n) begin
      @(negedge clk_2f);
      check_all();
      start = 1'b0;
      drive_phy(50, mm);
      @(posedge clk_2f);
    end
  endtask

  task automatic run_case(input logic [1:0] m, input logic [31:0] s, input int inj,
                          input int abort_at);
    logic [31:0] q[$];
    logic [31:0] v;
    logic        mm;
    int          nu, last_c, ign_b;
    v = s;
`ifdef PHY_STIM_LFSR_EN
    if (m == 2'd2 && s == 32'd0) v = '1;
`endif
    q.delete();
    for (int k = 0; k < NA; k++) begin
      q.push_back(v);
      v = ref_next(v, m);
    end
    @(negedge clk_2f);
    check_all();
    mode = m; seed = s; start = 1'b1;
    drive_phy(inj, mm);
    @(posedge clk_2f);
    ec_a = 0; ec_b = 0; eer_a = 0; eer_b = 0;
    last_c = 1 + (NA - 1) * (GA + 1) + DA + 3;
    ign_b  = 1 + (NB - 1) * (GB + 1) + DB;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk_2f);
      mode = 2'($urandom); seed = $urandom;
      // Both pulses land while busy; the second coincides with b's DRAIN->DONE.
      start = (c == 3) || (c == ign_b);
      if (c == abort_at) begin
        start = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk_2f);
        reset = 1'b0;
        return;
      end
      model_at(NA, GA, DA, c, ev_a, eb_a, edn_a, nu);
      ed_a = q[nu];
      model_at(NB, GB, DB, c, ev_b, eb_b, edn_b, nu);
      ed_b = q[nu];
      check_all();
      drive_phy(inj, mm);
      if (mm && eb_a) begin
        eer_a = 1;
        if (ec_a < MAXA) ec_a++;
      end
      if (mm && eb_b) begin
        eer_b = 1;
        if (ec_b < MAXB) ec_b++;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    model_reset();
    #3 reset = 1'b1;
    repeat (2) @(posedge clk_2f);
    @(negedge clk_2f);
    check_all();
    reset = 1'b0;
    idle_cycles(3);

    run_case(2'd0, 32'hFFFFFFFF, 0, 0);
    check_eq("a.last", data_a, 32'hFFFFF9C0);
    check_eq("b.last", data_b, 32'hFFFFFFFB);
    run_case(2'd1, 32'hFFFFFFFE, 0, 0);
    idle_cycles(4);
    run_case(2'($urandom_range(3)), $urandom, 30, 0);
    run_case(2'd3, $urandom, 0, 0);
    run_case(2'd1, $urandom, 20, 10);
    idle_cycles(2);
    run_case(2'd2, 32'd0, 10, 0);
    run_case(2'($urandom_range(3)), $urandom, 5, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
